// File: rtl/systolic_array_param_if.sv
// systolic_array_param_if: operand stream into the systolic array
//   in_valid  beat on a_data/b_data is valid
//   in_ready  array accepts a beat (transfer when in_valid && in_ready)
//   a_data    west operands, row r at [r*DATA_W +: DATA_W]
//   b_data    north operands, column c at [c*DATA_W +: DATA_W]
interface systolic_array_param_if #(
   parameter int ROWS   = 4,
   parameter int COLS   = 4,
   parameter int DATA_W = 16
) ();
   logic                     in_valid;
   logic                     in_ready;
   logic [ROWS*DATA_W-1:0]   a_data;
   logic [COLS*DATA_W-1:0]   b_data;
   modport master (output in_valid, a_data, b_data, input in_ready);
   modport slave  (input in_valid, a_data, b_data, output in_ready);
endinterface

// File: rtl/systolic_array_param.sv
// systolic_array_param: output-stationary ROWS x COLS signed matrix multiplier C = A x B
//   clk, aresetn        clock, synchronous active-low reset
//   start_i, k_len_i    begin a multiply of inner length k_len_i (sampled in IDLE)
//   in_if               operand stream (slave side)
//   busy_o, done_o      busy in LOAD/DRAIN, one-cycle pulse when results are final
//   rd_row_i, rd_col_i  result select; rd_data_o is the registered C[row][col]
module systolic_array_param #(
   parameter int ROWS   = 4,
   parameter int COLS   = 4,
   parameter int DATA_W = 16,
   parameter int ACC_W  = 40
) (
   input  logic                 clk,
   input  logic                 aresetn,
   input  logic                 start_i,
   input  logic [15:0]          k_len_i,
   systolic_array_param_if.slave in_if,
   output logic                 busy_o,
   output logic                 done_o,
   input  logic [3:0]           rd_row_i,
   input  logic [3:0]           rd_col_i,
   output logic [ACC_W-1:0]     rd_data_o
);
   localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
   localparam int DW = $clog2(ROWS + COLS);
   logic [1:0]                  state_q, state_d;
   logic [15:0]                 klen_q, cnt_q;
   logic [DW-1:0]               dcnt_q;
   logic                        fire, last_beat, go;
   // bit DATA_W of the west path is the valid tag; it travels with the A operand
   logic [DATA_W:0]             ws_q [ROWS][ROWS];
   logic [DATA_W-1:0]           ns_q [COLS][COLS];
   logic [DATA_W:0]             a_q  [ROWS][COLS];
   logic [DATA_W:0]             a_in [ROWS][COLS];
   logic [DATA_W-1:0]           b_q  [ROWS][COLS];
   logic [DATA_W-1:0]           b_in [ROWS][COLS];
   logic signed [2*DATA_W-1:0]  prod [ROWS][COLS];
   logic [ACC_W-1:0]            acc_q [ROWS][COLS];
   logic [ACC_W-1:0]            rd_d, rd_q;

   assign in_if.in_ready = state_q == LOAD;
   assign fire           = in_if.in_ready && in_if.in_valid;
   assign last_beat      = fire && (cnt_q + 16'd1 == klen_q);
   assign go             = state_q == IDLE && start_i;
   assign busy_o         = state_q == LOAD || state_q == DRAIN;
   assign done_o         = state_q == DONE;
   assign rd_data_o      = rd_q;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start_i) state_d = (k_len_i == 16'd0) ? DRAIN : LOAD;
         LOAD:    if (last_beat) state_d = DRAIN;
         DRAIN:   if (dcnt_q == DW'(ROWS + COLS - 2)) state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   // Row r enters the grid after r skew stages, column c after c; inside the grid
   // each PE forwards its operands east/south through one register.
   always_comb begin
      for (int r = 0; r < ROWS; r++) begin
         a_in[r][0] = ws_q[r][r];
         for (int c = 1; c < COLS; c++) a_in[r][c] = a_q[r][c-1];
      end
      for (int c = 0; c < COLS; c++) begin
         b_in[0][c] = ns_q[c][c];
         for (int r = 1; r < ROWS; r++) b_in[r][c] = b_q[r-1][c];
      end
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            prod[r][c] = (2*DATA_W)'($signed(a_in[r][c][DATA_W-1:0])) *
                         (2*DATA_W)'($signed(b_in[r][c]));
   end

   always_comb begin
      rd_d = '0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            if (rd_row_i == 4'(r) && rd_col_i == 4'(c)) rd_d = acc_q[r][c];
   end

   always_ff @(posedge clk) begin
      if (!aresetn) begin
         state_q <= IDLE;
         klen_q  <= '0;
         cnt_q   <= '0;
         dcnt_q  <= '0;
         rd_q    <= '0;
         for (int r = 0; r < ROWS; r++)
            for (int j = 0; j < ROWS; j++) ws_q[r][j] <= '0;
         for (int c = 0; c < COLS; c++)
            for (int j = 0; j < COLS; j++) ns_q[c][j] <= '0;
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
               a_q[r][c]   <= '0;
               b_q[r][c]   <= '0;
               acc_q[r][c] <= '0;
            end
      end else begin
         state_q <= state_d;
         rd_q    <= rd_d;
         dcnt_q  <= (state_q == DRAIN) ? dcnt_q + 1'b1 : '0;
         if (go) begin
            klen_q <= k_len_i;
            cnt_q  <= '0;
         end else if (fire) begin
            cnt_q  <= cnt_q + 16'd1;
         end
         for (int r = 0; r < ROWS; r++) begin
            ws_q[r][0] <= {fire, in_if.a_data[r*DATA_W +: DATA_W]};
            for (int j = 1; j < ROWS; j++) ws_q[r][j] <= ws_q[r][j-1];
         end
         for (int c = 0; c < COLS; c++) begin
            ns_q[c][0] <= in_if.b_data[c*DATA_W +: DATA_W];
            for (int j = 1; j < COLS; j++) ns_q[c][j] <= ns_q[c][j-1];
         end
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
               a_q[r][c]   <= a_in[r][c];
               b_q[r][c]   <= b_in[r][c];
               acc_q[r][c] <= go ? '0 :
                              a_in[r][c][DATA_W] ? acc_q[r][c] + ACC_W'(prod[r][c]) : acc_q[r][c];
            end
      end
   end
endmodule

// File: doc/systolic_array_param.md
SYSTOLIC_ARRAY_PARAM -- requirements
Module: systolic_array_param

Interface
REQ-001 Parameter ROWS, default 4, number of PE rows (1..16).
REQ-002 Parameter COLS, default 4, number of PE columns (1..16).
REQ-003 Parameter DATA_W, default 16, signed operand width.
REQ-004 Parameter ACC_W, default 40, signed accumulator width (>= 2*DATA_W).
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 aresetn  in  1  reset, synchronous and active-low.
REQ-007 start  in  1  pulse that begins a matrix multiply; sampled only in IDLE.
REQ-008 k_len  in  16  inner-dimension length; captured with start.
REQ-009 in_valid  in  1  beat on a_data/b_data is valid.
REQ-010 in_ready  out  1  array accepts a beat; transfer when in_valid && in_ready.
REQ-011 a_data  in  ROWS*DATA_W  west operands; row r at bits [r*DATA_W +: DATA_W], value A[r][k].
REQ-012 b_data  in  COLS*DATA_W  north operands; column c at bits [c*DATA_W +: DATA_W], value B[k][c].
REQ-013 busy  out  1  high in LOAD and DRAIN.
REQ-014 done  out  1  one-cycle pulse when every result is final.
REQ-015 rd_row  in  4  result row index.
REQ-016 rd_col  in  4  result column index.
REQ-017 rd_data  out  ACC_W  registered C[rd_row][rd_col].

Function
REQ-018 The block SHALL compute C = A x B (ROWS x COLS), output-stationary: one ACC_W accumulator per PE.
REQ-019 The FSM SHALL have the states IDLE, LOAD, DRAIN and DONE.
REQ-020 In IDLE, start=1 SHALL clear all accumulators, latch k_len, and go to LOAD, or to DRAIN if k_len=0.
REQ-021 LOAD SHALL hold in_ready=1, count accepted beats, and go to DRAIN on the beat that makes the count equal to k_len.
REQ-022 In LOAD, in_valid=0 cycles SHALL be bubbles: the valid tag travels with the data, and PEs accumulate only on a tagged pair.
REQ-023 Row r operands SHALL be skewed by r register stages, and column c by c stages; operands pass east/south through one register per PE.
REQ-024 A beat accepted in cycle t SHALL update PE(r,c) at the end of cycle t+1+r+c.
REQ-025 DRAIN SHALL last exactly ROWS+COLS-1 cycles, then go to DONE. done SHALL be asserted in cycle t_last+ROWS+COLS.
REQ-026 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-027 With k_len=0, done SHALL still follow start after the drain period, and all results SHALL be 0.
REQ-028 Each PE SHALL form a full-precision signed product (2*DATA_W), sign-extend it to ACC_W, and add it modulo 2^ACC_W (wrap, no saturation).
REQ-029 rd_data SHALL update one cycle after rd_row/rd_col are presented, and SHALL return 0 for rd_row>=ROWS or rd_col>=COLS.
REQ-030 Results SHALL remain stable and readable from done until the next accepted start.
REQ-031 start while busy or in DONE SHALL be ignored.
REQ-032 in_ready SHALL be 0 outside LOAD, and beats offered there SHALL be dropped.

Reset
REQ-033 aresetn=0 at a rising edge SHALL force IDLE, and clear all accumulators, skew registers, valid tags and counters.
REQ-034 After reset, the outputs SHALL be: in_ready=0, busy=0, done=0, rd_data=0.
REQ-035 Reset mid-LOAD or mid-DRAIN SHALL abort the operation with no done pulse; the next start SHALL behave as from power-up.

Verification
REQ-036 Identity (ROWS=COLS=4): A=I, B[k][c]=10k+c, k_len=4, continuous valid -> done at t_last+8; C[r][c]=10r+c.
REQ-037 Bubbles: same data with in_valid toggling 1,0,1,0 -> identical C; done 8 cycles after the 4th accepted beat.
REQ-038 Signed extremes (DATA_W=16, ACC_W=40): all operands -32768, k_len=4 -> every C = 4*2^30 = 4294967296.
REQ-039 Wrap (ACC_W=32): all operands -32768, k_len=2 -> every C = 2^31, which reads as -2147483648 (0x80000000).
REQ-040 k_len=0 -> done 8 cycles after start; all reads 0; rd_row=5 reads 0.
REQ-041 Reset mid-LOAD after 2 beats -> no done, all reads 0; a new start with k_len=1, A=all 3, B=all 2 gives every C=6.
